// File: rtl/register_skew_pipe_pkg.sv
// Shared helpers for the skew pipe: per-lane delay, deepest lane, parameter sanity.
package register_skew_pipe_pkg;

  // Delay of one lane: the least-delayed lane gets base_delay and each further lane adds step.
  function automatic int lane_delay(input int lane, input int base_delay, input int step,
                                    input int reverse, input int channels);
    int k;
    k = (reverse != 0) ? (channels - 1 - lane) : lane;
    return base_delay + step * k;
  endfunction

  // Depth of the deepest lane; this is how long busy can stay high after the last valid input.
  function automatic int max_depth(input int base_delay, input int step, input int channels);
    return base_delay + step * (channels - 1);
  endfunction

  // Legal configurations only. A zero-depth lane would be a combinational path, so it is rejected.
  function automatic bit params_ok(input int width, input int channels,
                                   input int base_delay, input int step);
    return (width >= 1) && (channels >= 1) && (base_delay >= 1) && (step >= 0);
  endfunction

endpackage

// File: rtl/register_skew_pipe_delay_line.sv
// One lane of the skew pipe: DEPTH registered {valid, data} stages with stall and flush.
module skew_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             any_valid
);

  logic [DEPTH-1:0] vld;
  logic [WIDTH-1:0] dat [DEPTH];

  // Shift chain: reset and clear wipe every stage, otherwise advance only when enabled.
  // Invalid entries carry zero data so the output is clean whenever out_valid is low.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      vld <= '0;
      for (int s = 0; s < DEPTH; s++) dat[s] <= '0;
    end else if (en) begin
      vld[0] <= in_valid;
      dat[0] <= in_valid ? in_data : '0;
      for (int s = 1; s < DEPTH; s++) begin
        vld[s] <= vld[s-1];
        dat[s] <= dat[s-1];
      end
    end
  end

  // Outputs come straight from the last stage; any_valid feeds the pipe-wide busy flag.
  always_comb begin
    out_valid = vld[DEPTH-1];
    out_data  = dat[DEPTH-1];
    any_valid = |vld;
  end

endmodule

// File: rtl/register_skew_pipe.sv
// Multi-lane registered delay line producing the diagonal operand wavefront for the PE array.
module register_skew_pipe
  import register_skew_pipe_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int BASE_DELAY = 1,
  parameter int STEP       = 1,
  parameter int REVERSE    = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      clear,
  input  logic                      in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       out_valid,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      busy
);

  logic [CHANNELS-1:0] lane_busy;

  if (!params_ok(WIDTH, CHANNELS, BASE_DELAY, STEP)) begin : g_bad_params
    $error("register_skew_pipe: need WIDTH>=1, CHANNELS>=1, BASE_DELAY>=1, STEP>=0");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    localparam int DEPTH = lane_delay(i, BASE_DELAY, STEP, REVERSE, CHANNELS);

    skew_delay_line #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_line (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_data   (in_data[i*WIDTH +: WIDTH]),
      .out_valid (out_valid[i]),
      .out_data  (out_data[i*WIDTH +: WIDTH]),
      .any_valid (lane_busy[i])
    );
  end

  // Busy while any lane still holds a valid entry anywhere in its chain.
  always_comb begin
    busy = |lane_busy;
  end

endmodule

// File: tb/tb_register_skew_pipe.sv
// Bench for register_skew_pipe: directed table, reverse-skew sequence, randomized run vs. a queue model.
module tb_register_skew_pipe;

  logic        clk = 1'b0;
  logic        reset, en, clear, in_valid;
  logic [31:0] in_data;
  logic [3:0]  out_valid0, out_valid1;
  logic [31:0] out_data0, out_data1;
  logic        busy0, busy1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  register_skew_pipe #(.WIDTH(8), .CHANNELS(4), .BASE_DELAY(1), .STEP(1), .REVERSE(0)) dut0 (
    .clk(clk), .reset(reset), .en(en), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid0), .out_data(out_data0), .busy(busy0));

  register_skew_pipe #(.WIDTH(8), .CHANNELS(4), .BASE_DELAY(1), .STEP(2), .REVERSE(1)) dut1 (
    .clk(clk), .reset(reset), .en(en), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid1), .out_data(out_data1), .busy(busy1));

  // Reference model: history of vectors accepted on enabled edges, newest first.
  // A lane with delay D shows the entry accepted D enabled edges ago.
  typedef struct { bit v; logic [31:0] d; } ent_t;
  ent_t hist[$];

  function automatic int dly(input int lane, input int base, input int step, input bit rev);
    return base + step * (rev ? (3 - lane) : lane);
  endfunction

  task automatic model_view(input int base, input int step, input bit rev,
                            output logic [3:0] ev, output logic [31:0] ed, output logic eb);
    int dmax;
    ev = '0; ed = '0; eb = 1'b0; dmax = 0;
    for (int i = 0; i < 4; i++) begin
      int d;
      d = dly(i, base, step, rev);
      if (d > dmax) dmax = d;
      if (hist.size() >= d && hist[d-1].v) begin
        ev[i] = 1'b1;
        ed[i*8 +: 8] = hist[d-1].d[i*8 +: 8];
      end
    end
    for (int k = 0; k < dmax && k < hist.size(); k++) if (hist[k].v) eb = 1'b1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // One clock: drive inputs, take the edge, advance the model, then compare both DUTs against it.
  task automatic step(input bit r, input bit c, input bit e, input bit v, input logic [31:0] d);
    logic [3:0] ev; logic [31:0] ed; logic eb;
    ent_t x;
    reset = r; clear = c; en = e; in_valid = v; in_data = d;
    @(posedge clk);
    if (r || c) hist.delete();
    else if (e) begin
      x.v = v; x.d = v ? d : 32'h0;
      hist.push_front(x);
      if (hist.size() > 8) void'(hist.pop_back());
    end
    #1;
    model_view(1, 1, 1'b0, ev, ed, eb);
    chk("m0_valid", {28'h0, out_valid0}, {28'h0, ev});
    chk("m0_data",  out_data0, ed);
    chk("m0_busy",  {31'h0, busy0}, {31'h0, eb});
    model_view(1, 2, 1'b1, ev, ed, eb);
    chk("m1_valid", {28'h0, out_valid1}, {28'h0, ev});
    chk("m1_data",  out_data1, ed);
    chk("m1_busy",  {31'h0, busy1}, {31'h0, eb});
  endtask

  typedef struct {
    bit r, c, e, v;
    logic [31:0] d;
    logic [3:0]  ev;
    logic [31:0] ed;
    bit          eb;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit c, bit e, bit v, logic [31:0] d,
                              logic [3:0] ev, logic [31:0] ed, bit eb);
    vec_t t;
    t.r = r; t.c = c; t.e = e; t.v = v; t.d = d; t.ev = ev; t.ed = ed; t.eb = eb;
    return t;
  endfunction

  initial begin
    reset = 1'b1; clear = 1'b0; en = 1'b1; in_valid = 1'b1; in_data = 32'hFFFF_FFFF;

    // reset held three cycles with valid input, then one idle cycle
    for (int k = 0; k < 3; k++) tbl.push_back(mk(1,0,1,1,32'hFFFF_FFFF, 4'b0000, 32'h0, 0));
    tbl.push_back(mk(0,0,1,0,32'h0, 4'b0000, 32'h0, 0));
    // single vector skew
    tbl.push_back(mk(0,0,1,1,32'h4433_2211, 4'b0001, 32'h0000_0011, 1));
    tbl.push_back(mk(0,0,1,0,32'h0,         4'b0010, 32'h0000_2200, 1));
    tbl.push_back(mk(0,0,1,0,32'h0,         4'b0100, 32'h0033_0000, 1));
    tbl.push_back(mk(0,0,1,0,32'h0,         4'b1000, 32'h4400_0000, 1));
    tbl.push_back(mk(0,0,1,0,32'h0,         4'b0000, 32'h0,         0));
    // stall two cycles after acceptance; inputs during the stall are ignored
    tbl.push_back(mk(0,0,1,1,32'h4433_2211, 4'b0001, 32'h0000_0011, 1));
    tbl.push_back(mk(0,0,0,1,32'hAAAA_AAAA, 4'b0001, 32'h0000_0011, 1));
    tbl.push_back(mk(0,0,0,1,32'hAAAA_AAAA, 4'b0001, 32'h0000_0011, 1));
    tbl.push_back(mk(0,0,1,0,32'h0,         4'b0010, 32'h0000_2200, 1));
    tbl.push_back(mk(0,0,1,0,32'h0,         4'b0100, 32'h0033_0000, 1));
    tbl.push_back(mk(0,0,1,0,32'h0,         4'b1000, 32'h4400_0000, 1));
    tbl.push_back(mk(0,0,1,0,32'h0,         4'b0000, 32'h0,         0));
    // clear mid-stream drops everything, including the vector presented with it
    tbl.push_back(mk(0,0,1,1,32'h0101_0101, 4'b0001, 32'h0000_0001, 1));
    tbl.push_back(mk(0,0,1,1,32'h0202_0202, 4'b0011, 32'h0000_0102, 1));
    tbl.push_back(mk(0,1,1,1,32'h0303_0303, 4'b0000, 32'h0,         0));
    tbl.push_back(mk(0,0,1,1,32'h0404_0404, 4'b0001, 32'h0000_0004, 1));
    tbl.push_back(mk(0,1,1,0,32'h0,         4'b0000, 32'h0,         0));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(0,0,1,0,32'h0, 4'b0000, 32'h0, 0));
    // reset mid-stream behaves like clear
    tbl.push_back(mk(0,0,1,1,32'h0505_0505, 4'b0001, 32'h0000_0005, 1));
    tbl.push_back(mk(0,0,1,1,32'h0606_0606, 4'b0011, 32'h0000_0506, 1));
    tbl.push_back(mk(1,0,1,1,32'h0707_0707, 4'b0000, 32'h0,         0));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(0,0,1,0,32'h0, 4'b0000, 32'h0, 0));
    // clear while stalled still flushes
    tbl.push_back(mk(0,0,1,1,32'h0808_0808, 4'b0001, 32'h0000_0008, 1));
    tbl.push_back(mk(0,1,0,1,32'h0909_0909, 4'b0000, 32'h0,         0));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(0,0,1,0,32'h0, 4'b0000, 32'h0, 0));
    // back-to-back vectors: no bubbles in the wavefront
    tbl.push_back(mk(0,0,1,1,32'h1111_1111, 4'b0001, 32'h0000_0011, 1));
    tbl.push_back(mk(0,0,1,1,32'h2222_2222, 4'b0011, 32'h0000_1122, 1));
    tbl.push_back(mk(0,0,1,1,32'h3333_3333, 4'b0111, 32'h0011_2233, 1));
    tbl.push_back(mk(0,0,1,1,32'h4444_4444, 4'b1111, 32'h1122_3344, 1));
    tbl.push_back(mk(0,0,1,0,32'h0,         4'b1110, 32'h2233_4400, 1));

    foreach (tbl[n]) begin
      step(tbl[n].r, tbl[n].c, tbl[n].e, tbl[n].v, tbl[n].d);
      chk($sformatf("tbl%0d_valid", n), {28'h0, out_valid0}, {28'h0, tbl[n].ev});
      chk($sformatf("tbl%0d_data", n),  out_data0, tbl[n].ed);
      chk($sformatf("tbl%0d_busy", n),  {31'h0, busy0}, {31'h0, tbl[n].eb});
    end

    // reverse skew on dut1: lane3 after 1 edge, lane2 after 3, lane1 after 5, lane0 after 7
    for (int k = 0; k < 8; k++) step(0, 0, 1, 0, 32'h0);
    step(0, 0, 1, 1, 32'h4433_2211);
    for (int k = 0; k < 8; k++) begin
      logic [3:0]  ev;
      logic [31:0] ed;
      logic [31:0] vec;
      vec = 32'h4433_2211;
      ev = '0; ed = '0;
      if (k == 0) begin ev[3] = 1'b1; ed[31:24] = vec[31:24]; end
      if (k == 2) begin ev[2] = 1'b1; ed[23:16] = vec[23:16]; end
      if (k == 4) begin ev[1] = 1'b1; ed[15:8]  = vec[15:8];  end
      if (k == 6) begin ev[0] = 1'b1; ed[7:0]   = vec[7:0];   end
      chk($sformatf("rev%0d_valid", k), {28'h0, out_valid1}, {28'h0, ev});
      chk($sformatf("rev%0d_data", k),  out_data1, ed);
      chk($sformatf("rev%0d_busy", k),  {31'h0, busy1}, {31'h0, (k < 7)});
      step(0, 0, 1, 0, 32'h0);
    end

    // randomized traffic with occasional stalls, flushes and resets
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 59) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 4) != 0, $urandom_range(0, 2) != 0, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
